// File: rtl/iomem_bfm_pkg.sv
// Shared FSM encoding, register-map offsets and width helper for the iomem slave BFM.
package iomem_bfm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } bfm_state_e;

    // Special registers occupy the top of the bank, counted down from NUM_REGS.
    localparam int unsigned REG_ACCESS_CNT = 2;
    localparam int unsigned REG_IRQ_TRIG   = 1;

    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/iomem_slave_bfm_irq_pulse_gen.sv
// One IRQ channel: reloadable down-counter, output high while the count is non-zero.
module irq_pulse_gen
    import iomem_bfm_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trig_i,
    output logic irq_o
);

    localparam int unsigned CntW = log2_ceil(PULSE_LEN + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // A trigger while counting reloads, stretching the pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (trig_i) begin
            cnt_d = CntW'(PULSE_LEN);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign irq_o = (cnt_q != '0);

endmodule

// File: rtl/iomem_slave_bfm.sv
// picosoc iomem slave: wait-stated responder with scratch bank, access counter and IRQ triggers.
module iomem_slave_bfm
    import iomem_bfm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0300_0000,
    parameter int unsigned NUM_REGS      = 8,
    parameter int unsigned WAIT_CYCLES   = 2,
    parameter int unsigned NUM_IRQ       = 3,
    parameter int unsigned IRQ_PULSE_LEN = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               iomem_valid,
    output logic               iomem_ready,
    input  logic [3:0]         iomem_wstrb,
    input  logic [31:0]        iomem_addr,
    input  logic [31:0]        iomem_wdata,
    output logic [31:0]        iomem_rdata,
    output logic [NUM_IRQ-1:0] irq
);

    localparam int unsigned    IdxW         = log2_ceil(NUM_REGS);
    localparam logic [7:0]     BaseHi       = BASE_ADDR[31:24];
    localparam logic [IdxW-1:0] IdxAccessCnt = IdxW'(NUM_REGS - REG_ACCESS_CNT);
    localparam logic [IdxW-1:0] IdxIrqTrig   = IdxW'(NUM_REGS - REG_IRQ_TRIG);

    bfm_state_e state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] bank_q [NUM_REGS];
    logic [31:0] bank_d [NUM_REGS];
    logic [31:0] cnt_q, cnt_d;

    logic                hit;
    logic                ack;
    logic                wr;
    logic [IdxW-1:0]     idx;
    logic [NUM_IRQ-1:0]  trig;
    logic                unused_addr;

    assign hit = iomem_valid && (iomem_addr[31:24] == BaseHi);
    assign idx = iomem_addr[2 +: IdxW];
    assign ack = (state_q == StResp);
    assign wr  = ack && (iomem_wstrb != 4'b0000);

    // Bits between the index and the window compare are don't-care: the bank aliases.
    assign unused_addr = ^{iomem_addr[23:2+IdxW], iomem_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    wait_d  = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                if (!iomem_valid) begin
                    state_d = StIdle;
                end else if (wait_q <= 4'd1) begin
                    state_d = StResp;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        iomem_ready = ack;
        iomem_rdata = 32'd0;
        if (ack) begin
            if (idx == IdxAccessCnt) begin
                iomem_rdata = cnt_q;
            end else if (idx == IdxIrqTrig) begin
                iomem_rdata = 32'(irq);
            end else begin
                iomem_rdata = bank_q[idx];
            end
        end
    end

    // All side effects land at the closing edge of the response cycle.
    always_comb begin
        bank_d = bank_q;
        cnt_d  = cnt_q;
        trig   = '0;
        if (ack) begin
            if (wr && (idx == IdxAccessCnt)) begin
                cnt_d = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            if (wr) begin
                if (idx == IdxIrqTrig) begin
                    trig = iomem_wdata[NUM_IRQ-1:0];
                end else if (idx != IdxAccessCnt) begin
                    for (int b = 0; b < 4; b++) begin
                        if (iomem_wstrb[b]) bank_d[idx][8*b +: 8] = iomem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bank_q <= '{default: 32'd0};
            cnt_q  <= 32'd0;
        end else begin
            bank_q <= bank_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq
        irq_pulse_gen #(
            .PULSE_LEN(IRQ_PULSE_LEN)
        ) u_irq_pulse_gen (
            .clk_i (clk),
            .rst_ni(resetn),
            .trig_i(trig[i]),
            .irq_o (irq[i])
        );
    end

endmodule
